// File: rtl/if_fetch_queue_pkg.sv
// Shared constants and sizing helpers for the instruction-fetch queue slice.
package if_fetch_queue_pkg;

    localparam int PC_SIZE_DEFAULT     = 10;
    localparam int INSTR_WIDTH_DEFAULT = 32;
    localparam int QUEUE_DEPTH_DEFAULT = 4;
    localparam int RESET_PC_DEFAULT    = 0;

    // Pointer width for a circular buffer of the given depth (at least 1 bit).
    function automatic int qptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counter width: must be able to hold the value "depth" itself.
    function automatic int qcount_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A queue entry is packed as {pc, instr}; this is its total width.
    function automatic int entry_width(input int pc_size, input int instr_width);
        return pc_size + instr_width;
    endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// Bundle of control, memory-load and IF/ID handshake signals around the fetch queue.
interface if_fetch_queue_if
    import if_fetch_queue_pkg::*;
#(
    parameter int PC_SIZE     = PC_SIZE_DEFAULT,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
);

    logic                                  fetch_enable;
    logic                                  redirect_valid;
    logic [PC_SIZE-1:0]                    redirect_pc;
    logic                                  mem_we;
    logic [PC_SIZE-1:0]                    mem_waddr;
    logic [INSTR_WIDTH-1:0]                mem_wdata;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [PC_SIZE-1:0]                    out_pc;
    logic [INSTR_WIDTH-1:0]                out_instr;
    logic [qcount_width(QUEUE_DEPTH)-1:0]  queue_count;

    // The fetch stage: consumes control/load inputs, presents the queue head.
    modport master (
        input  fetch_enable,
        input  redirect_valid,
        input  redirect_pc,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata,
        input  out_ready,
        output out_valid,
        output out_pc,
        output out_instr,
        output queue_count
    );

    // The surrounding pipeline: PC-select, loader and decode.
    modport slave (
        output fetch_enable,
        output redirect_valid,
        output redirect_pc,
        output mem_we,
        output mem_waddr,
        output mem_wdata,
        output out_ready,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        input  queue_count
    );

endinterface

// File: rtl/if_fetch_queue_instr_mem_sync.sv
// Instruction memory: one synchronous read port, one write port, read-first.
module instr_mem_sync #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write and registered read share the edge; the read sees the pre-write contents.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the fetch PC, the instruction memory and a small instruction
// queue feeding decode through a valid/ready handshake, with redirect/flush.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int PC_SIZE     = PC_SIZE_DEFAULT,
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
    parameter int QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    if_fetch_queue_if.master  bus
);

    localparam int PW = qptr_width(QUEUE_DEPTH);
    localparam int CW = qcount_width(QUEUE_DEPTH);
    localparam int EW = entry_width(PC_SIZE, INSTR_WIDTH);
    localparam logic [PC_SIZE-1:0] RESET_PC_V  = RESET_PC[PC_SIZE-1:0];
    localparam logic [PC_SIZE-1:0] PC_ONE      = {{(PC_SIZE-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0]      PTR_ONE     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW:0]        DEPTH_LIMIT = (CW+1)'(QUEUE_DEPTH);

    logic [PC_SIZE-1:0]     fetch_pc_q, fetch_pc_d;
    logic                   inflight_q, inflight_d;
    logic [PC_SIZE-1:0]     inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;

    logic [EW-1:0]          entry_mem [QUEUE_DEPTH];
    logic [EW-1:0]          head_entry;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    logic                   redirect;
    logic                   pop;
    logic                   push;
    logic                   issue;
    logic [CW:0]            occupancy;

    assign redirect   = bus.redirect_valid;
    assign head_entry = entry_mem[rd_ptr_q];

    // Handshake decisions; a redirect suppresses pop, push and issue alike.
    always_comb begin
        pop       = (count_q != '0) && bus.out_ready && !redirect;
        push      = inflight_q && !redirect;
        // Reserve a slot for the in-flight read so a push can never overflow.
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        issue     = bus.fetch_enable && !redirect && (occupancy < DEPTH_LIMIT);
    end

    // Next fetch PC, in-flight tag and queue pointer/count updates.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (redirect) begin
            fetch_pc_d = bus.redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + PC_ONE;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset drops everything including any pending response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_PC_V;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // Queue storage: the memory response lands at the tail tagged with its PC.
    always_ff @(posedge clock) begin
        if (push) begin
            entry_mem[wr_ptr_q] <= {inflight_pc_q, mem_rdata};
        end
    end

    instr_mem_sync #(
        .ADDR_W (PC_SIZE),
        .DATA_W (INSTR_WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (bus.mem_we),
        .waddr (bus.mem_waddr),
        .wdata (bus.mem_wdata),
        .re    (issue),
        .raddr (fetch_pc_q),
        .rdata (mem_rdata)
    );

    // Head is presented only while occupied; an empty queue reads as zero.
    always_comb begin
        bus.out_valid   = (count_q != '0);
        bus.queue_count = count_q;
        bus.out_pc      = '0;
        bus.out_instr   = '0;
        if (count_q != '0) begin
            bus.out_pc    = head_entry[EW-1:INSTR_WIDTH];
            bus.out_instr = head_entry[INSTR_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for the fetch queue: stimulus queues expected {pc, instr}
// responses, a negedge monitor checks every accepted head against them.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam int PCW = 10;
    localparam int IW  = 32;
    localparam int QD  = 4;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [IW-1:0]  instr;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int   n_vec     = 0;
    int   n_bad     = 0;
    int   pop_count = 0;
    exp_t sb [$];
    logic [IW-1:0] mem_model [0:1023];

    if_fetch_queue_if #(.PC_SIZE(PCW), .INSTR_WIDTH(IW), .QUEUE_DEPTH(QD)) bus ();

    if_fetch_queue #(
        .PC_SIZE     (PCW),
        .INSTR_WIDTH (IW),
        .QUEUE_DEPTH (QD),
        .RESET_PC    (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Monitor: every handshake that will complete on the next edge is checked.
    always @(negedge clock) begin
        exp_t e;
        if (reset && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            pop_count++;
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h, required no delivery",
                         bus.out_pc, bus.out_instr);
            end else begin
                e = sb.pop_front();
                if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                    n_bad++;
                    $display("FAIL pop: got pc=%h instr=%h, required pc=%h instr=%h",
                             bus.out_pc, bus.out_instr, e.pc, e.instr);
                end else begin
                    $display("pop pc=%h instr=%h ok", bus.out_pc, bus.out_instr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("check %s = %h ok", name, got);
        end
    endtask

    task automatic expect_pc(input int pc);
        exp_t e;
        e.pc    = PCW'(pc);
        e.instr = mem_model[pc];
        sb.push_back(e);
    endtask

    // Accept n heads, then drop out_ready; bounded so a stuck DUT cannot hang the run.
    task automatic consume(input int n);
        int target;
        bit done;
        target        = pop_count + n;
        done          = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            tick();
            if (pop_count >= target) done = 1'b1;
        end
        bus.out_ready = 1'b0;
        n_vec++;
        if (!done) begin
            n_bad++;
            $display("FAIL consume_timeout: got %0d pops, required %0d", pop_count, target);
        end
    endtask

    task automatic redirect_to(input int pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = PCW'(pc);
        tick();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        bus.fetch_enable   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.mem_we         = 1'b0;
        bus.mem_waddr      = '0;
        bus.mem_wdata      = '0;
        bus.out_ready      = 1'b0;
        for (int a = 0; a < 1024; a++) mem_model[a] = 32'(32'h100 + a);

        #2;
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_pc",    64'(bus.out_pc),    64'd0);
        check("rst_instr", 64'(bus.out_instr), 64'd0);
        check("rst_count", 64'(bus.queue_count), 64'd0);
        tick();
        tick();
        reset = 1'b1;

        // Load memory with fetch held off.
        for (int a = 0; a < 1024; a++) begin
            if (a < 8 || a >= 1008) begin
                bus.mem_we    = 1'b1;
                bus.mem_waddr = PCW'(a);
                bus.mem_wdata = mem_model[a];
                tick();
            end
        end
        bus.mem_we = 1'b0;
        tick();
        check("idle_valid", 64'(bus.out_valid), 64'd0);
        check("idle_count", 64'(bus.queue_count), 64'd0);

        // Release fetch with decode ready: two-cycle latency, then one per cycle.
        for (int i = 0; i < 4; i++) expect_pc(i);
        bus.fetch_enable = 1'b1;
        bus.out_ready    = 1'b1;
        tick();
        check("lat_edge1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("lat_edge2_valid", 64'(bus.out_valid), 64'd1);
        check("stream_pc0",      64'(bus.out_pc),    64'd0);
        check("stream_instr0",   64'(bus.out_instr), 64'h100);
        tick();
        check("stream_pc1", 64'(bus.out_pc), 64'd1);
        tick();
        check("stream_pc2", 64'(bus.out_pc), 64'd2);
        tick();
        check("stream_pc3", 64'(bus.out_pc), 64'd3);
        tick();
        bus.out_ready = 1'b0;

        // Back-pressure: the queue saturates and holds.
        repeat (8) tick();
        check("full_count",   64'(bus.queue_count), 64'd4);
        check("full_head_pc", 64'(bus.out_pc),      64'd4);
        repeat (4) tick();
        check("full_hold_count", 64'(bus.queue_count), 64'd4);
        for (int i = 4; i < 8; i++) expect_pc(i);
        consume(4);
        repeat (8) tick();
        check("refill_count", 64'(bus.queue_count), 64'd4);

        // Redirect while full: flush, then the new stream after two edges.
        redirect_to(10'h3F0);
        check("redir_valid", 64'(bus.out_valid), 64'd0);
        check("redir_count", 64'(bus.queue_count), 64'd0);
        tick();
        check("redir_edge1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("redir_edge2_valid", 64'(bus.out_valid), 64'd1);
        check("redir_pc",          64'(bus.out_pc),    64'h3F0);
        check("redir_instr",       64'(bus.out_instr), 64'(mem_model[10'h3F0]));
        repeat (6) tick();
        expect_pc(10'h3F0);
        expect_pc(10'h3F1);
        consume(2);

        // Back-to-back redirects right after pops (read in flight): last wins.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'h3F8;
        tick();
        bus.redirect_pc    = 10'h3FE;
        tick();
        bus.redirect_valid = 1'b0;
        check("redir2_count", 64'(bus.queue_count), 64'd0);
        expect_pc(10'h3FE);
        expect_pc(10'h3FF);
        expect_pc(0);
        expect_pc(1);
        consume(4);

        // Write to address 5 on the same edge it is read: old data comes back.
        expect_pc(5);
        redirect_to(5);
        bus.mem_we    = 1'b1;
        bus.mem_waddr = 10'd5;
        bus.mem_wdata = 32'h0000DEAD;
        tick();
        bus.mem_we    = 1'b0;
        mem_model[5]  = 32'h0000DEAD;
        consume(1);
        expect_pc(5);
        redirect_to(5);
        consume(1);

        // Asynchronous reset with three queued entries.
        redirect_to(0);
        repeat (4) tick();
        check("pre_reset_count", 64'(bus.queue_count), 64'd3);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid),   64'd0);
        check("async_rst_count", 64'(bus.queue_count), 64'd0);
        check("async_rst_pc",    64'(bus.out_pc),      64'd0);
        check("async_rst_instr", 64'(bus.out_instr),   64'd0);
        tick();
        tick();
        reset = 1'b1;
        expect_pc(0);
        expect_pc(1);
        tick();
        check("restart_edge1_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check("restart_valid", 64'(bus.out_valid), 64'd1);
        check("restart_pc",    64'(bus.out_pc),    64'd0);
        consume(2);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
